ysyx_210544_clint_multi: RTL and testbench
==========================================

YSYX_210544_CLINT_MULTI -- requirements
Module: ysyx_210544_clint_multi

Interface
REQ-001 SHALL have parameter NHART, default 2, meaning number of harts served (1..16).
REQ-002 SHALL have parameter TICK_DIV, default 1, meaning clk cycles per mtime increment (1..256).
REQ-003 SHALL have port clk  input  1  clock, all state updated on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_addr  input  16  byte offset from CLINT base; bits [2:0] ignored.
REQ-006 SHALL have port i_ren  input  1  read request, one access per asserted cycle.
REQ-007 SHALL have port o_rdata  output  64  read data, valid when o_rvalid=1, else 0.
REQ-008 SHALL have port o_rvalid  output  1  read data valid, one-cycle pulse.
REQ-009 SHALL have port i_wen  input  1  write request.
REQ-010 SHALL have port i_wdata  input  64  write data.
REQ-011 SHALL have port i_wstrb  input  8  byte enables; byte k written only if i_wstrb[k]=1.
REQ-012 SHALL have port o_mtip  output  NHART  machine timer interrupt per hart.
REQ-013 SHALL have port o_msip  output  NHART  machine software interrupt per hart.

Function
REQ-014 Map SHALL be: msip[h] at 0x0000+8*h (bit 0 only), mtimecmp[h] at 0x4000+8*h, mtime at 0xBFF8.
REQ-015 Prescaler SHALL count 0..TICK_DIV-1; mtime SHALL increment by 1 in the cycle the prescaler wraps from TICK_DIV-1 to 0; TICK_DIV=1 increments every cycle.
REQ-016 mtime SHALL wrap from 2^64-1 to 0 without a flag.
REQ-017 A write to mtime SHALL take priority over a same-cycle increment; the prescaler SHALL reset to 0 on any mtime write.
REQ-018 o_mtip[h] SHALL equal (mtime >= mtimecmp[h]), unsigned 64-bit, evaluated from registered values; a write therefore affects o_mtip from the following cycle.
REQ-019 o_msip[h] SHALL equal msip[h] bit 0; msip bits [63:1] SHALL read 0 and ignore writes.
REQ-020 Read latency SHALL be 1 cycle: i_ren at cycle N gives o_rvalid=1 and o_rdata at N+1, reflecting register values before any write in cycle N.
REQ-021 Back-to-back reads SHALL be accepted every cycle without stalls.
REQ-022 Reads of unmapped offsets or hart index >= NHART SHALL return 0 with o_rvalid=1; such writes SHALL be ignored.
REQ-023 Simultaneous i_ren and i_wen SHALL both be performed, the read returning pre-write data.
REQ-024 o_rdata SHALL be 0 in every cycle o_rvalid=0.

Reset
REQ-025 On rst: mtime=0, prescaler=0, all mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, all msip=0, o_rvalid=0, o_rdata=0; hence o_mtip=0 and o_msip=0 in the first cycle after rst.
REQ-026 rst asserted while a read is outstanding SHALL cancel it (no o_rvalid pulse) and ignore same-cycle writes.

Configuration
REQ-027 Macro YSYX_210544_CLINT_MSIP_EN defined: msip registers implemented per REQ-014/019.
REQ-028 Macro undefined: no msip storage; msip offsets read 0, writes ignored, o_msip tied to 0; all else unchanged.

Verification (NHART=2, TICK_DIV=4, macro defined)
REQ-029 Release rst, idle 40 cycles, read 0xBFF8 -> o_rdata=10 (+/-1 per read-issue cycle, checked exactly against model), o_mtip=2'b00.
REQ-030 Write mtimecmp[1]=20 (wstrb=8'hFF) at mtime=5 -> o_mtip[1] rises the cycle after mtime reaches 20; o_mtip[0] stays 0.
REQ-031 Write mtime=64'hFFFF_FFFF_FFFF_FFFF with mtimecmp[0]=0 -> mtime wraps to 0 after 4 cycles; o_mtip[0] stays 1.
REQ-032 Write 0x0008 data=64'h3 wstrb=8'h01 -> o_msip=2'b10, read 0x0008 returns 1; write 0 clears it; repeat with macro undefined -> o_msip=0, read 0.
REQ-033 Write 0x4000 data=64'h1122_3344_5566_7788 wstrb=8'h0F over reset value -> read returns 64'hFFFF_FFFF_5566_7788; same-cycle read returns all-ones.
REQ-034 Read 0x4010 (hart 2) and 0x8000 -> o_rvalid=1, o_rdata=0; assert rst the cycle after an i_ren -> no o_rvalid pulse, all registers at reset values.

Source files
------------

// File: rtl/ysyx_210544_clint_multi.sv
// Multi-hart CLINT: a prescaled 64-bit mtime shared by all harts, plus per-hart mtimecmp and msip.
// Define YSYX_210544_CLINT_MSIP_EN to implement msip storage; otherwise msip reads 0 and o_msip is tied low.
module ysyx_210544_clint_multi #(
    parameter int NHART    = 2,
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      i_addr,
    input  logic             i_ren,
    output logic [63:0]      o_rdata,
    output logic             o_rvalid,
    input  logic             i_wen,
    input  logic [63:0]      i_wdata,
    input  logic [7:0]       i_wstrb,
    output logic [NHART-1:0] o_mtip,
    output logic [NHART-1:0] o_msip
);

    localparam int            PW            = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST      = PW'(TICK_DIV - 1);
    localparam logic [12:0]   MTIMECMP_BASE = 13'h0800;
    localparam logic [12:0]   MTIME_WORD    = 13'h17FF;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIMECMP,
        REG_MTIME
    } reg_kind_e;

    logic [12:0]   word;
    logic          addr_unused;
    reg_kind_e     kind;
    logic [3:0]    hart;

    logic [PW-1:0] prescale;
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp [NHART];
    logic [63:0]   rd_data;
    logic [63:0]   rdata_q;
    logic          rvalid_q;
    logic          wr_mtime;
    logic          wr_cmp;

    // Registers are 64-bit aligned, so the low three address bits never select anything.
    assign word        = i_addr[15:3];
    assign addr_unused = ^i_addr[2:0];

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                                input logic [63:0] new_val,
                                                input logic [7:0]  strb);
        logic [63:0] res;
        res = old_val;
        for (int k = 0; k < 8; k++) begin
            if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
        end
        return res;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        kind = REG_NONE;
        hart = '0;
        if (word == MTIME_WORD) begin
            kind = REG_MTIME;
        end else if (word >= MTIMECMP_BASE && word < MTIMECMP_BASE + 13'(NHART)) begin
            kind = REG_MTIMECMP;
            hart = 4'(word - MTIMECMP_BASE);
        end else if (word < 13'(NHART)) begin
            kind = REG_MSIP;
            hart = word[3:0];
        end
    end

    assign wr_mtime = i_wen && (kind == REG_MTIME);
    assign wr_cmp   = i_wen && (kind == REG_MTIMECMP);

    // A software write to mtime wins over the tick and restarts the prescaler.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime    <= '0;
            prescale <= '0;
        end else if (wr_mtime) begin
            mtime    <= merge_bytes(mtime, i_wdata, i_wstrb);
            prescale <= '0;
        end else if (prescale == PRE_LAST) begin
            mtime    <= mtime + 64'd1;
            prescale <= '0;
        end else begin
            prescale <= prescale + PW'(1);
        end
    end

    // NOTE: mtimecmp is a small register array, not a RAM, so each entry is reset explicitly.
    always_ff @(posedge clk) begin
        for (int h = 0; h < NHART; h++) begin
            if (rst) begin
                mtimecmp[h] <= '1;
            end else if (wr_cmp && hart == 4'(h)) begin
                mtimecmp[h] <= merge_bytes(mtimecmp[h], i_wdata, i_wstrb);
            end
        end
    end

    for (genvar h = 0; h < NHART; h++) begin : g_mtip
        assign o_mtip[h] = (mtime >= mtimecmp[h]);
    end

`ifdef YSYX_210544_CLINT_MSIP_EN
    logic [NHART-1:0] msip;

    // Only bit 0 exists, so only byte lane 0 can change it.
    always_ff @(posedge clk) begin
        for (int h = 0; h < NHART; h++) begin
            if (rst) begin
                msip[h] <= 1'b0;
            end else if (i_wen && kind == REG_MSIP && hart == 4'(h) && i_wstrb[0]) begin
                msip[h] <= i_wdata[0];
            end
        end
    end

    assign o_msip = msip;
`else
    assign o_msip = '0;
`endif

    always_comb begin
        rd_data = '0;
        case (kind)
            REG_MTIME: rd_data = mtime;
            REG_MTIMECMP: begin
                for (int h = 0; h < NHART; h++) begin
                    if (hart == 4'(h)) rd_data = mtimecmp[h];
                end
            end
            REG_MSIP: begin
`ifdef YSYX_210544_CLINT_MSIP_EN
                for (int h = 0; h < NHART; h++) begin
                    if (hart == 4'(h)) rd_data = {63'd0, msip[h]};
                end
`endif
            end
            default: rd_data = '0;
        endcase
    end

    // Read data is captured before this cycle's write lands, giving pre-write values on a same-cycle access.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= i_ren;
            rdata_q  <= i_ren ? rd_data : '0;
        end
    end

    // A reset arriving while a read response is due drops that response.
    assign o_rvalid = rvalid_q & ~rst;
    assign o_rdata  = (rvalid_q && !rst) ? rdata_q : '0;

endmodule

// File: tb/tb_ysyx_210544_clint_multi.sv
// Scoreboard bench for ysyx_210544_clint_multi (NHART=2, TICK_DIV=4); msip expectations follow YSYX_210544_CLINT_MSIP_EN.
module tb_ysyx_210544_clint_multi;

    localparam int NHART    = 2;
    localparam int TICK_DIV = 4;
`ifdef YSYX_210544_CLINT_MSIP_EN
    localparam bit MSIP_EN = 1'b1;
`else
    localparam bit MSIP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [15:0]      i_addr = '0;
    logic             i_ren = 1'b0;
    logic [63:0]      o_rdata;
    logic             o_rvalid;
    logic             i_wen = 1'b0;
    logic [63:0]      i_wdata = '0;
    logic [7:0]       i_wstrb = '0;
    logic [NHART-1:0] o_mtip;
    logic [NHART-1:0] o_msip;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q [$];
    string       tag_q [$];
    logic [63:0] mon_exp;
    string       mon_tag;

    logic [63:0] mt_m;
    logic [1:0]  pre_m;
    logic        rose;

    always #5 clk = ~clk;

    ysyx_210544_clint_multi #(.NHART(NHART), .TICK_DIV(TICK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_addr   (i_addr),
        .i_ren    (i_ren),
        .o_rdata  (o_rdata),
        .o_rvalid (o_rvalid),
        .i_wen    (i_wen),
        .i_wdata  (i_wdata),
        .i_wstrb  (i_wstrb),
        .o_mtip   (o_mtip),
        .o_msip   (o_msip)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference mtime: a divide-by-4 tick; the bench only writes mtime with all byte lanes enabled.
    always @(posedge clk) begin
        if (rst) begin
            mt_m  <= '0;
            pre_m <= '0;
        end else if (i_wen && i_addr[15:3] == 13'h17FF) begin
            mt_m  <= i_wdata;
            pre_m <= '0;
        end else if (pre_m == 2'd3) begin
            mt_m  <= mt_m + 64'd1;
            pre_m <= '0;
        end else begin
            pre_m <= pre_m + 2'd1;
        end
    end

    always @(negedge clk) begin
        if (o_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                check(mon_tag, o_rdata, mon_exp);
            end
        end else begin
            check("rdata_idle_zero", o_rdata, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [63:0] e, input string tag);
        i_ren  = 1'b1;
        i_addr = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        tick();
        i_ren = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s);
        i_wen   = 1'b1;
        i_addr  = a;
        i_wdata = d;
        i_wstrb = s;
        tick();
        i_wen = 1'b0;
    endtask

    task automatic rdwr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s,
                        input logic [63:0] e, input string tag);
        i_ren   = 1'b1;
        i_wen   = 1'b1;
        i_addr  = a;
        i_wdata = d;
        i_wstrb = s;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        tick();
        i_ren = 1'b0;
        i_wen = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        check("reset_mtip", o_mtip, 2'b00);
        check("reset_msip", o_msip, 2'b00);
        check("reset_rvalid", o_rvalid, 1'b0);

        // Free-running mtime: 40 idle cycles at divide-by-4 gives 10.
        repeat (40) tick();
        check("idle_mtip", o_mtip, 2'b00);
        rd(16'hBFF8, 64'd10, "mtime_after_40");

        // Timer compare on hart 1 with mtime preset to 5.
        wr(16'hBFF8, 64'd5, 8'hFF);
        wr(16'h4008, 64'd20, 8'hFF);
        rose = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (mt_m == 64'd21) break;
            check("mtip_ramp", o_mtip, {mt_m >= 64'd20, 1'b0});
            if (mt_m == 64'd20 && o_mtip[1]) rose = 1'b1;
            tick();
        end
        check("mtip1_rose_at_20", rose, 1'b1);
        rd(16'h4008, 64'd20, "mtimecmp1_readback");

        // Partial-strobe write over the all-ones reset value, with a same-cycle read.
        rdwr(16'h4000, 64'h1122_3344_5566_7788, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, "cmp0_same_cycle_read");
        rd(16'h4000, 64'hFFFF_FFFF_5566_7788, "cmp0_partial_write");
        check("mtip_after_partial", o_mtip, 2'b10);

        // Software interrupt bits.
        wr(16'h0000, 64'h1, 8'hFE);
        check("msip_lane0_disabled", o_msip, 2'b00);
        wr(16'h0008, 64'h3, 8'h01);
        check("msip1_set", o_msip, MSIP_EN ? 2'b10 : 2'b00);
        rd(16'h0008, MSIP_EN ? 64'd1 : 64'd0, "msip1_read");
        rd(16'h0000, 64'd0, "msip0_read");
        wr(16'h0010, 64'h1, 8'hFF);
        check("msip_hart2_ignored", o_msip, MSIP_EN ? 2'b10 : 2'b00);
        wr(16'h0008, 64'h0, 8'h01);
        check("msip1_clear", o_msip, 2'b00);
        rd(16'h0008, 64'd0, "msip1_read_cleared");

        // mtime wrap with mtimecmp[0]=0; back-to-back reads across the wrap.
        wr(16'h4000, 64'd0, 8'hFF);
        check("mtip0_cmp_zero", o_mtip, 2'b11);
        wr(16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        for (int c = 0; c < 4; c++) begin
            check("mtip_before_wrap", o_mtip, 2'b11);
            rd(16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, "mtime_before_wrap");
        end
        check("mtip_after_wrap", o_mtip, 2'b01);
        rd(16'hBFF8, 64'd0, "mtime_after_wrap");

        // Unmapped and out-of-range accesses.
        wr(16'h4010, 64'd7, 8'hFF);
        rd(16'h4010, 64'd0, "cmp_hart2_read");
        rd(16'h8000, 64'd0, "unmapped_read");
        rd(16'h0010, 64'd0, "msip_hart2_read");
        rd(16'h4000, 64'd0, "cmp0_untouched");
        rd(16'h4008, 64'd20, "cmp1_untouched");

        // Reset while a read is outstanding: no response, writes ignored, state back to reset values.
        wr(16'h0008, 64'h1, 8'h01);
        i_ren  = 1'b1;
        i_addr = 16'hBFF8;
        tick();
        i_ren   = 1'b0;
        rst     = 1'b1;
        i_wen   = 1'b1;
        i_addr  = 16'h4008;
        i_wdata = 64'd5;
        i_wstrb = 8'hFF;
        tick();
        rst   = 1'b0;
        i_wen = 1'b0;
        check("post_rst_mtip", o_mtip, 2'b00);
        check("post_rst_msip", o_msip, 2'b00);
        check("post_rst_rvalid", o_rvalid, 1'b0);
        rd(16'hBFF8, 64'd0, "post_rst_mtime");
        rd(16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, "post_rst_cmp0");
        rd(16'h4008, 64'hFFFF_FFFF_FFFF_FFFF, "post_rst_cmp1");
        rd(16'h0008, 64'd0, "post_rst_msip1");

        repeat (3) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
